// File: rtl/fp_norm_round_pipe_if.sv
// Handshake bundle for the FP normalise/round output stage.
// Upstream beat: in_valid/in_ready plus the raw fields in_sign, in_exp
// (signed biased, EXP_W+2 bits), in_mant (2*MAN_W+2 bits, two integer bits),
// in_special (00 normal, 01 zero, 10 inf, 11 NaN) and in_rnd (00 RNE, 01 RTZ,
// 10 toward +inf, 11 toward -inf).
// Downstream beat: out_valid/out_ready with out_data {sign, exp, fraction}
// and out_flags {overflow, underflow, inexact}.
// master = the side that produces input beats and consumes results,
// slave  = the stage itself.
interface fp_norm_round_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_sign;
    logic [EXP_W+1:0]         in_exp;
    logic [2*MAN_W+1:0]       in_mant;
    logic [1:0]               in_special;
    logic [1:0]               in_rnd;
    logic                     out_valid;
    logic                     out_ready;
    logic [EXP_W+MAN_W:0]     out_data;
    logic [2:0]               out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_special, in_rnd, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_special, in_rnd, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fp_norm_round_pipe.sv
// Final stage of the FP datapath: normalise, denormalise, round (four IEEE
// modes), saturate on overflow and pack, with a two-register valid/ready
// pipeline (S1 = normalise, S2 = round/pack and output register).
// Ports: clk (rising edge), rst (async active-high), bus (slave side of
// fp_norm_round_pipe_if carrying the input beat, the packed result and flags).
module fp_norm_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    fp_norm_round_pipe_if.slave bus
);
    localparam int MW     = 2*MAN_W + 2;
    localparam int XW     = EXP_W + 3;          // working exponent, one bit of headroom
    localparam int LZW    = $clog2(MW);
    localparam int SH_MAX = MAN_W + 3;          // beyond this everything is sticky
    localparam int SHW    = $clog2(SH_MAX + 1);
    localparam logic signed [XW-1:0] EXP_CLAMP = XW'(1 << EXP_W);
    localparam logic [EXP_W+1:0]     EXP_OVF   = (EXP_W+2)'((1 << EXP_W) - 1);

    // Handshake enables
    logic en1_s, en2_s;

    // S1 state
    logic               v1_r, sign1_r, g1_r, rb1_r, st1_r, tiny1_r;
    logic [EXP_W+1:0]   exp1_r;
    logic [MAN_W:0]     kept1_r;
    logic [1:0]         rnd1_r, spec1_r;

    // S2 state (output register)
    logic               v2_r;
    logic [EXP_W+MAN_W:0] data2_r;
    logic [2:0]         flags2_r;

    // Stall propagates back combinationally so a draining pipe never bubbles
    always_comb begin
        en2_s = !v2_r || bus.out_ready;
        en1_s = !v1_r || en2_s;
    end

    assign bus.in_ready  = en1_s;
    assign bus.out_valid = v2_r;
    assign bus.out_data  = data2_r;
    assign bus.out_flags = flags2_r;

    // ---------------- S1: normalise ----------------
    logic [LZW-1:0]         lz_s;
    logic signed [XW-1:0]   exp_w_s, sh_full_s;
    logic [MW-2:0]          norm_s, den_s, mv_s;
    logic                   sticky0_s, tiny_s, lost_s, st_s;
    logic [SHW-1:0]         sh_s;
    logic [EXP_W+1:0]       exp_n_s;
    logic [1:0]             spec_n_s;

    // Leading-zero count measured from the weight-2^0 bit
    always_comb begin
        lz_s = '0;
        for (int i = 0; i < MW-1; i++) begin
            lz_s = bus.in_mant[i] ? LZW'(MW-2-i) : lz_s;
        end
    end

    // Normalise to a hidden bit at MW-2, then right-shift tiny values
    always_comb begin
        if (bus.in_mant[MW-1]) begin
            norm_s    = bus.in_mant[MW-1:1];
            sticky0_s = bus.in_mant[0];
            exp_w_s   = $signed({bus.in_exp[EXP_W+1], bus.in_exp}) + XW'(1);
        end else begin
            norm_s    = bus.in_mant[MW-2:0] << lz_s;
            sticky0_s = 1'b0;
            exp_w_s   = $signed({bus.in_exp[EXP_W+1], bus.in_exp})
                        - $signed({{(XW-LZW){1'b0}}, lz_s});
        end
        tiny_s    = (exp_w_s <= $signed(XW'(0)));
        sh_full_s = $signed(XW'(1)) - exp_w_s;
        if (sh_full_s > $signed(XW'(SH_MAX))) begin
            sh_s = SHW'(SH_MAX);
        end else begin
            sh_s = sh_full_s[SHW-1:0];
        end
        den_s  = norm_s >> sh_s;
        lost_s = |(norm_s & ~({(MW-1){1'b1}} << sh_s));
        mv_s   = tiny_s ? den_s : norm_s;
        st_s   = sticky0_s || (tiny_s && lost_s) || (|mv_s[MAN_W-3:0]);
        // Clamping large exponents keeps the overflow decision but avoids wrap
        if (tiny_s) begin
            exp_n_s = '0;
        end else if (exp_w_s >= EXP_CLAMP) begin
            exp_n_s = EXP_CLAMP[EXP_W+1:0];
        end else begin
            exp_n_s = exp_w_s[EXP_W+1:0];
        end
        // A zero mantissa is carried as the zero special
        if (bus.in_special == 2'b00 && bus.in_mant == '0) begin
            spec_n_s = 2'b01;
        end else begin
            spec_n_s = bus.in_special;
        end
    end

    // S1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r <= 1'b0; sign1_r <= 1'b0; exp1_r <= '0; kept1_r <= '0;
            g1_r <= 1'b0; rb1_r <= 1'b0; st1_r <= 1'b0; tiny1_r <= 1'b0;
            rnd1_r <= 2'b00; spec1_r <= 2'b00;
        end else if (en1_s) begin
            v1_r <= bus.in_valid;
            if (bus.in_valid) begin
                sign1_r <= bus.in_sign;
                exp1_r  <= exp_n_s;
                kept1_r <= mv_s[MW-2:MAN_W];
                g1_r    <= mv_s[MAN_W-1];
                rb1_r   <= mv_s[MAN_W-2];
                st1_r   <= st_s;
                tiny1_r <= tiny_s;
                rnd1_r  <= bus.in_rnd;
                spec1_r <= spec_n_s;
            end
        end
    end

    // ---------------- S2: round and pack ----------------
    logic                   inx_s, inc_s, carry_s, ovf_s, to_inf_s;
    logic [MAN_W+1:0]       sum_s;
    logic [MAN_W-1:0]       frac_s;
    logic [EXP_W+1:0]       exp_f_s;
    logic [EXP_W+MAN_W:0]   data_s;
    logic [2:0]             flags_s;

    // Rounding increment, renormalisation and result selection
    always_comb begin
        inx_s = g1_r || rb1_r || st1_r;
        case (rnd1_r)
            2'b00:   inc_s = g1_r && (rb1_r || st1_r || kept1_r[0]);
            2'b01:   inc_s = 1'b0;
            2'b10:   inc_s = !sign1_r && inx_s;
            2'b11:   inc_s = sign1_r && inx_s;
            default: inc_s = 1'b0;
        endcase
        case (rnd1_r)
            2'b00:   to_inf_s = 1'b1;
            2'b01:   to_inf_s = 1'b0;
            2'b10:   to_inf_s = !sign1_r;
            2'b11:   to_inf_s = sign1_r;
            default: to_inf_s = 1'b1;
        endcase
        sum_s   = {1'b0, kept1_r} + (MAN_W+2)'(inc_s);
        carry_s = sum_s[MAN_W+1];
        frac_s  = carry_s ? sum_s[MAN_W:1] : sum_s[MAN_W-1:0];
        // A denormal rounding into the hidden bit lands at exponent 1
        exp_f_s = exp1_r + (EXP_W+2)'(carry_s)
                  + (EXP_W+2)'(tiny1_r && sum_s[MAN_W]);
        ovf_s   = (exp_f_s >= EXP_OVF);
        case (spec1_r)
            2'b00: begin
                if (ovf_s) begin
                    flags_s = 3'b101;
                    if (to_inf_s) begin
                        data_s = {sign1_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else begin
                        data_s = {sign1_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                    end
                end else begin
                    flags_s = {1'b0, tiny1_r && inx_s, inx_s};
                    data_s  = {sign1_r, exp_f_s[EXP_W-1:0], frac_s};
                end
            end
            2'b01: begin
                flags_s = 3'b000;
                data_s  = {sign1_r, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            end
            2'b10: begin
                flags_s = 3'b000;
                data_s  = {sign1_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            default: begin
                flags_s = 3'b000;
                data_s  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            end
        endcase
    end

    // S2 / output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_r     <= 1'b0;
            data2_r  <= '0;
            flags2_r <= 3'b000;
        end else if (en2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                data2_r  <= data_s;
                flags2_r <= flags_s;
            end
        end
    end
endmodule

// File: doc/fp_norm_round_pipe.md
Name: fp_norm_round_pipe

Overview:
- Parametrised, pipelined final stage of the FP multiplier/adder datapath.
- Takes a raw sign, an unbounded exponent, an extended mantissa and a special-case code.
- Performs normalisation, denormal right-shift, IEEE-754 rounding (four modes) and overflow/underflow saturation, then emits a packed result plus exception flags.
- Generalises the fixed-8-bit exponent former to any EXP_W/MAN_W and adds a valid/ready pipeline with backpressure.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width; MW = 2*MAN_W+2 is the input mantissa width.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, stage can accept a beat.
- in_sign, input, 1, result sign.
- in_exp, input, EXP_W+2, signed biased exponent of the in_mant value; may be <=0 or >=2^EXP_W-1.
- in_mant, input, MW, unsigned; bit MW-1 weight 2^1, bit MW-2 weight 2^0.
- in_special, input, 2, 00 normal, 01 zero, 10 infinity, 11 NaN.
- in_rnd, input, 2, 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, 1+EXP_W+MAN_W, {sign, exp, fraction}.
- out_flags, output, 3, {overflow, underflow, inexact}.

Behaviour:
- Reset: all stage valids, out_valid, out_data and out_flags are 0. Reset mid-operation discards all in-flight beats; out_valid falls asynchronously.
- Pipeline: two register stages, S1 and S2 (S2 is the output register).
  - en2 = !S2.v | out_ready; en1 = !S1.v | en2; in_ready = en1 (combinational, no bubble).
  - A beat transfers on valid & ready. Latency is 2 cycles with out_ready high; full throughput is 1 beat/cycle.
  - While out_valid=1 and out_ready=0, out_data and out_flags are held stable. Order is preserved.
- S1 (normalise), for in_special=00:
  - If in_mant == 0: result is zero, flags 0.
  - If in_mant[MW-1]=1: shift right 1, exp+1. The shifted-out bit feeds sticky.
  - Otherwise: lz = leading-zero count from bit MW-2; shift left lz, exp-lz.
  - If the resulting exp <= 0: the value is tiny. Shift right by 1-exp, saturating at MAN_W+3 with all bits going to sticky. Set exp=0.
  - S1 registers: sign, exp (EXP_W+2), MAN_W+1 kept bits, guard, round, sticky, tiny, rnd, special.
- S2 (round and pack):
  - inc rule per mode:
    - RNE: G & (R|S|lsb).
    - RTZ: 0.
    - +inf: !sign & (G|R|S).
    - -inf: sign & (G|R|S).
  - inexact = G|R|S.
  - Mantissa carry-out renormalises, exp+1. A denormal that rounds up into the hidden bit becomes exp=1.
  - If final exp >= 2^EXP_W-1: overflow=1, inexact=1.
    - Result is infinity for RNE, for +inf with sign=0, and for -inf with sign=1.
    - Otherwise result is max finite {sign, 2^EXP_W-2, all ones}.
  - underflow = tiny & inexact.
- Specials bypass arithmetic and set flags=0:
  - zero: {sign, 0, 0}.
  - infinity: {sign, all ones, 0}.
  - NaN: canonical quiet NaN {0, all ones, 1, 0...}.
- Width rule: all exponent arithmetic is signed EXP_W+2 bits and must not wrap for lz up to MW-1.

Test Plan:
- Normal value: in_mant=1.0 (bit MW-2 only), in_exp=127, sign 0, RNE -> out_data 0x3F800000, flags 000, out_valid exactly 2 cycles after acceptance.
- Overflow: in_mant bit MW-1 set, in_exp=254.
  - RNE -> 0x7F800000, flags 101.
  - RTZ -> 0x7F7FFFFF, flags 101.
  - -inf with sign 0 -> 0x7F7FFFFF.
- Denormals:
  - in_mant=1.0, in_exp=-3 -> 0x00080000, flags 000.
  - in_mant=1.0+2^-MAN_W, in_exp=-3 -> inexact, underflow, flags 011.
- Rounding ties, in_exp=127:
  - mant 1+2^-24, RNE -> 0x3F800000, flags 001.
  - mant 1+2^-23+2^-24, RNE -> 0x3F800002.
  - mant 2-2^-25, RNE -> carry to 0x40000000.
- Backpressure: out_ready=0 for 5 cycles while offering 4 back-to-back beats -> exactly 2 accepted, then in_ready=0; out_data stable; after release, beats emerge in order with no loss or duplication.
- Special and reset: in_special=11 -> 0x7FC00000.
  - Assert rst with S1 and S2 valid -> out_valid=0 immediately.
  - After release, the first new beat appears 2 cycles after acceptance.
